dcache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the core's memory-stage outputs and main memory.
- Consumes the core's ALUOut (address), WriteData, MemWrite and LoadW.
- Returns ReadData plus dhit, which the core uses as its data-side stall/advance signal.
- Refills whole 4-word lines from memory through a req/ready handshake.

---
 rtl/dcache_pkg.sv | 23 ++
 rtl/dcache_array.sv | 58 +++++
 rtl/dcache_ctrl.sv | 127 ++++++++++++
 tb/tb_dcache_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared state encoding and sizing helpers for the direct-mapped, write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } cacheState_t;

    localparam int OFFSET_BITS   = 2;
    localparam int LINE_BITS     = 128;
    localparam int ADDR_BITS     = 32;
    localparam int WORD_SEL_BITS = 2;

    function automatic int indexWidth(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tagWidth(input int lines);
        return ADDR_BITS - OFFSET_BITS - WORD_SEL_BITS - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid, tag and line storage for the data cache: combinational read, synchronous line or byte-merged word write.
module dcache_array
    import dcache_pkg::*;
#(
    parameter  int LINES = 16,
    localparam int IW    = indexWidth(LINES),
    localparam int TW    = tagWidth(LINES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IW-1:0]        index,
    output logic                 rdValid,
    output logic [TW-1:0]        rdTag,
    output logic [LINE_BITS-1:0] rdLine,
    input  logic                 lineWe,
    input  logic [TW-1:0]        lineTag,
    input  logic [LINE_BITS-1:0] lineData,
    input  logic                 wordWe,
    input  logic [1:0]           wordOffset,
    input  logic [3:0]           wordBe,
    input  logic [31:0]          wordData
);

    logic [LINES-1:0]     validQ;
    logic [TW-1:0]        tagQ  [LINES];
    logic [LINE_BITS-1:0] dataQ [LINES];
    logic [31:0]          oldWord;
    logic [31:0]          mergedWord;

    assign rdValid = validQ[index];
    assign rdTag   = tagQ[index];
    assign rdLine  = dataQ[index];

    assign oldWord    = dataQ[index][{wordOffset, 5'b00000} +: 32];
    assign mergedWord = {wordBe[3] ? wordData[31:24] : oldWord[31:24],
                         wordBe[2] ? wordData[23:16] : oldWord[23:16],
                         wordBe[1] ? wordData[15:8]  : oldWord[15:8],
                         wordBe[0] ? wordData[7:0]   : oldWord[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            validQ <= '0;
        end else if (lineWe) begin
            validQ[index] <= 1'b1;
        end
    end

    // Tags and data need no reset; a cleared valid bit hides whatever they hold.
    always_ff @(posedge clk) begin
        if (lineWe) begin
            tagQ[index]  <= lineTag;
            dataQ[index] <= lineData;
        end else if (wordWe) begin
            dataQ[index][{wordOffset, 5'b00000} +: 32] <= mergedWord;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with 4-word line refill.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic                 cpu_byte,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 dhit,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_be,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ready
);

    localparam int WB       = $clog2(WORDS_PER_LINE);
    localparam int IW       = indexWidth(LINES);
    localparam int TW       = tagWidth(LINES);
    localparam int INDEX_LO = OFFSET_BITS + WB;
    localparam int TAG_LO   = INDEX_LO + IW;

    cacheState_t          state;
    logic [IW-1:0]        lookupIndex;
    logic [TW-1:0]        lookupTag;
    logic                 arrValid;
    logic [TW-1:0]        arrTag;
    logic [LINE_BITS-1:0] arrLine;
    logic                 hit;
    logic                 lineWe;
    logic                 wordWe;

    // Outside IDLE the registered bus address names the line being refilled or written.
    assign lookupIndex = (state == IDLE) ? cpu_addr[INDEX_LO +: IW] : mem_addr[INDEX_LO +: IW];
    assign lookupTag   = (state == IDLE) ? cpu_addr[TAG_LO +: TW]   : mem_addr[TAG_LO +: TW];
    assign hit         = arrValid && (arrTag == lookupTag);
    assign cpu_rdata   = arrLine[{cpu_addr[OFFSET_BITS +: WB], 5'b00000} +: 32];

    assign lineWe = !reset && (state == REFILL) && mem_ready;
    assign wordWe = !reset && (state == WRITE) && mem_ready && hit;

    dcache_array #(
        .LINES(LINES)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .index     (lookupIndex),
        .rdValid   (arrValid),
        .rdTag     (arrTag),
        .rdLine    (arrLine),
        .lineWe    (lineWe),
        .lineTag   (mem_addr[TAG_LO +: TW]),
        .lineData  (mem_rdata),
        .wordWe    (wordWe),
        .wordOffset(mem_addr[OFFSET_BITS +: WB]),
        .wordBe    (mem_be),
        .wordData  (mem_wdata)
    );

    always_comb begin
        dhit = 1'b0;
        case (state)
            IDLE:    dhit = cpu_write ? 1'b0 : (cpu_read ? hit : 1'b1);
            WRITE:   dhit = mem_ready;
            default: dhit = 1'b0;
        endcase
    end

    // A store wins over a simultaneous load; the core re-presents the load afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_write) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[31:2], 2'b00};
                        mem_be    <= cpu_byte ? (4'b0001 << cpu_addr[1:0]) : 4'b1111;
                        mem_wdata <= cpu_byte ? {4{cpu_wdata[7:0]}} : cpu_wdata;
                    end else if (cpu_read && !hit) begin
                        state    <= REFILL;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'b0000;
                        mem_addr <= {cpu_addr[31:4], 4'b0000};
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0000;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random loads/stores against a line-level cache and memory model.
module tb_dcache_ctrl;

    localparam int LINES      = 16;
    localparam int IB         = $clog2(LINES);
    localparam int MAX_CYCLES = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic         cpu_write;
    logic         cpu_byte;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         dhit;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_be;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    always #5 clk = ~clk;

    dcache_ctrl #(
        .LINES(LINES),
        .WORDS_PER_LINE(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_read (cpu_read),
        .cpu_write(cpu_write),
        .cpu_byte (cpu_byte),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .dhit     (dhit),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    int vectors     = 0;
    int miscompares = 0;

    bit          modelValid [LINES];
    int unsigned modelTag   [LINES];
    logic [31:0] modelData  [LINES][4];
    logic [31:0] memW [int unsigned];

    function automatic logic [31:0] memRead(input int unsigned a);
        if (memW.exists(a)) return memW[a];
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    function automatic logic [127:0] memLine(input logic [31:0] a);
        logic [127:0] line;
        int unsigned  base;
        base = a & 32'hFFFF_FFF0;
        for (int w = 0; w < 4; w++) line[w*32 +: 32] = memRead(base + 4 * w);
        return line;
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] oldW, input logic [31:0] newW, input logic [3:0] be);
        logic [31:0] r;
        r = oldW;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = newW[b*8 +: 8];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, wanted %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < LINES; i++) modelValid[i] = 1'b0;
    endtask

    // One CPU access held until dhit; memory answers after lat cycles of mem_req.
    task automatic applyStimulus(input bit rd, input bit wr, input bit bt,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int lat);
        int unsigned idx, tagv, off;
        bit          isLoad, isStore, modelHit, needReq, done, sawReq;
        int          expCycles, cycles, reqCycles;
        logic [31:0] expAddr, expWdata, expData;
        logic [3:0]  expBe;

        idx      = (addr >> 4) % LINES;
        tagv     = addr >> (4 + IB);
        off      = (addr >> 2) & 3;
        isStore  = wr;
        isLoad   = rd && !wr;
        modelHit = modelValid[idx] && (modelTag[idx] == tagv);
        expBe    = bt ? (4'b0001 << addr[1:0]) : 4'b1111;
        expWdata = bt ? {4{wdata[7:0]}} : wdata;
        expData  = '0;

        if (isStore) begin
            expCycles = lat + 1;
            needReq   = 1'b1;
            expAddr   = addr & 32'hFFFF_FFFC;
            memW[expAddr] = mergeWord(memRead(expAddr), expWdata, expBe);
            if (modelHit) modelData[idx][off] = mergeWord(modelData[idx][off], expWdata, expBe);
        end else if (isLoad) begin
            expAddr = addr & 32'hFFFF_FFF0;
            if (modelHit) begin
                expCycles = 1;
                needReq   = 1'b0;
            end else begin
                expCycles = lat + 2;
                needReq   = 1'b1;
                for (int w = 0; w < 4; w++) modelData[idx][w] = memRead(expAddr + 4 * w);
                modelValid[idx] = 1'b1;
                modelTag[idx]   = tagv;
            end
            expData = modelData[idx][off];
        end else begin
            expCycles = 1;
            needReq   = 1'b0;
            expAddr   = '0;
        end

        cpu_read  = rd;
        cpu_write = wr;
        cpu_byte  = bt;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cycles    = 0;
        reqCycles = 0;
        done      = 1'b0;
        sawReq    = 1'b0;

        while (!done && cycles < MAX_CYCLES) begin
            @(negedge clk);
            cycles++;
            if (!rd && !wr && cycles == 1) mem_ready = 1'b1;
            if (mem_req) begin
                reqCycles++;
                if (!sawReq) begin
                    sawReq = 1'b1;
                    checkOutput("memAddr", mem_addr, expAddr);
                    checkOutput("memWe", {31'b0, mem_we}, {31'b0, isStore});
                    if (isStore) begin
                        checkOutput("memBe", {28'b0, mem_be}, {28'b0, expBe});
                        checkOutput("memWdata", mem_wdata, expWdata);
                    end
                end
                if (reqCycles == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = memLine(mem_addr);
                end
            end
            #1;
            if (dhit) begin
                done = 1'b1;
                if (isLoad) checkOutput("rdata", cpu_rdata, expData);
            end
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
        end

        checkOutput("cycles", cycles, expCycles);
        checkOutput("reqSeen", {31'b0, sawReq}, {31'b0, needReq});
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        if (!rd && !wr) begin
            @(negedge clk);
            checkOutput("idleReadyIgnored", {31'b0, mem_req}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetDuringRefill(input logic [31:0] addr);
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = addr;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstReqBefore", {31'b0, mem_req}, 32'd1);
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = memLine(addr);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        cpu_read  = 1'b0;
        @(negedge clk);
        checkOutput("rstReqDrop", {31'b0, mem_req}, 32'd0);
        checkOutput("rstDhit", {31'b0, dhit}, 32'd1);
        clearModel();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        int          op;

        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_byte  = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        clearModel();
        memW[32'h100] = 32'd1;
        memW[32'h104] = 32'd2;
        memW[32'h108] = 32'd3;
        memW[32'h10C] = 32'd4;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstMemReq", {31'b0, mem_req}, 32'd0);
        checkOutput("rstMemWe", {31'b0, mem_we}, 32'd0);
        checkOutput("rstMemBe", {28'b0, mem_be}, 32'd0);
        checkOutput("rstDhit", {31'b0, dhit}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] directed scenarios");
        applyStimulus(1, 0, 0, 32'h104, 32'h0, 3);
        applyStimulus(1, 0, 0, 32'h100, 32'h0, 2);
        applyStimulus(1, 0, 0, 32'h108, 32'h0, 2);
        applyStimulus(0, 1, 0, 32'h104, 32'hDEADBEEF, 2);
        applyStimulus(1, 0, 0, 32'h104, 32'h0, 2);
        applyStimulus(0, 1, 1, 32'h105, 32'h000000AA, 1);
        applyStimulus(1, 0, 0, 32'h104, 32'h0, 2);
        applyStimulus(1, 0, 0, 32'h100 + 16 * LINES, 32'h0, 2);
        applyStimulus(1, 0, 0, 32'h100, 32'h0, 1);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        resetDuringRefill(32'h300);
        applyStimulus(1, 0, 0, 32'h100, 32'h0, 2);

        $display("[TB] random accesses");
        for (int i = 0; i < 200; i++) begin
            addr = 32'h1000 | ($urandom_range(3, 0) << 8) | ($urandom_range(LINES - 1, 0) << 4)
                 | ($urandom_range(3, 0) << 2) | $urandom_range(3, 0);
            op = $urandom_range(99, 0);
            if (op < 50)
                applyStimulus(1, 0, 1'($urandom), addr, $urandom, $urandom_range(4, 1));
            else if (op < 85)
                applyStimulus(0, 1, 1'($urandom), addr, $urandom, $urandom_range(4, 1));
            else if (op < 92)
                applyStimulus(1, 1, 1'($urandom), addr, $urandom, $urandom_range(4, 1));
            else
                applyStimulus(0, 0, 0, addr, 32'h0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
